// File: rtl/cabac_rate_pkg.sv
// rtl/cabac_rate_pkg.sv - shared Golomb-Rice constants, FSM states and suffix-length helper
package cabac_rate_pkg;

    localparam int COEF_REMAIN_BIN_REDUCTION = 5;
    // Limited-mode prefix limit is this value minus the dynamic range M
    localparam int LIMITED_PREFIX_BASE       = 32 - COEF_REMAIN_BIN_REDUCTION;
    // Suffix accumulator width; unlimited mode at the prefix cap needs well over 32 bits
    localparam int GR_ACC_W                  = 64;

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        SUFFIX,
        DONE
    } gr_state_e;

    function automatic logic [6:0] gr_limited_pmax(input logic [4:0] m);
        return 7'(LIMITED_PREFIX_BASE) - {2'b00, m};
    endfunction

    function automatic logic [6:0] gr_suffix_len(
        input logic [6:0] p,
        input logic [3:0] r,
        input logic       limited,
        input logic [4:0] m
    );
        logic [6:0] len;
        if (p < 7'(COEF_REMAIN_BIN_REDUCTION)) begin
            len = {3'b000, r};
        end else if (limited && (p == gr_limited_pmax(m))) begin
            len = {2'b00, m};
        end else begin
            len = p - 7'(COEF_REMAIN_BIN_REDUCTION) + {3'b000, r};
        end
        return len;
    endfunction

endpackage

// File: rtl/golomb_rice_bin_decoder_symbol_build.sv
// rtl/golomb_rice_bin_decoder_symbol_build.sv - combinational prefix/suffix/rice to symbol mapping with saturation
module gr_symbol_build
    import cabac_rate_pkg::*;
#(
    parameter int SYM_W = 16
) (
    input  logic [6:0]          prefix,
    input  logic [GR_ACC_W-1:0] suffix,
    input  logic [3:0]          rice,
    output logic [SYM_W-1:0]    sym,
    output logic                overflow
);

    logic [GR_ACC_W-1:0] base;
    logic [GR_ACC_W-1:0] value;

    // Short prefixes are unary; long prefixes switch to the exponential escape form
    always_comb begin
        base = '0;
        if (prefix < 7'(COEF_REMAIN_BIN_REDUCTION)) begin
            base = GR_ACC_W'(prefix);
        end else begin
            base = (GR_ACC_W'(1) << (prefix - 7'(COEF_REMAIN_BIN_REDUCTION)))
                 + GR_ACC_W'(COEF_REMAIN_BIN_REDUCTION - 1);
        end
        value    = (base << rice) + suffix;
        overflow = |(value >> SYM_W);
        sym      = overflow ? '1 : value[SYM_W-1:0];
    end

endmodule

// File: rtl/golomb_rice_bin_decoder.sv
// rtl/golomb_rice_bin_decoder.sv - serial bypass-bin Golomb-Rice remainder decoder; GR_BITCOUNT_EN adds total_bits
module golomb_rice_bin_decoder
    import cabac_rate_pkg::*;
#(
    parameter int SYM_W      = 16,
    parameter int PREFIX_CAP = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      ui16AbsGoRice,
    input  logic             useLimitedPrefixLength,
    input  logic [4:0]       maxLog2TrDynamicRange,
    input  logic             bin_valid,
    input  logic             bin,
    output logic             bin_ready,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [SYM_W-1:0] sym,
    output logic             err,
    output logic             busy
`ifdef GR_BITCOUNT_EN
    ,
    output logic [7:0]       total_bits
`endif
);

    gr_state_e           state;
    gr_state_e           state_next;

    logic [3:0]          rice;
    logic                limited;
    logic [4:0]          range_m;
    logic [6:0]          prefix_cnt;
    logic [GR_ACC_W-1:0] suffix_reg;
    logic [6:0]          suffix_cnt;
    logic [6:0]          suffix_len;
    logic                cap_err;

    logic [6:0]          pmax;
    logic [6:0]          prefix_next;
    logic [6:0]          end_len;
    logic                prefix_end;

    logic [SYM_W-1:0]    built_sym;
    logic                built_ovf;

    // Only the low nibble of the rice parameter is meaningful
    logic                unused_rice_hi;
    assign unused_rice_hi = ^ui16AbsGoRice[15:4];

    // Prefix-termination decision for the bin currently presented
    always_comb begin
        pmax        = limited ? gr_limited_pmax(range_m) : 7'(PREFIX_CAP);
        prefix_next = bin ? (prefix_cnt + 7'd1) : prefix_cnt;
        end_len     = gr_suffix_len(prefix_next, rice, limited, range_m);
        prefix_end  = bin_valid && (!bin || (prefix_next == pmax));
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and bin handshake
    always_comb begin
        state_next = state;
        bin_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = PREFIX;
                end
            end
            PREFIX: begin
                bin_ready = 1'b1;
                if (prefix_end) begin
                    state_next = (end_len == 7'd0) ? DONE : SUFFIX;
                end
            end
            SUFFIX: begin
                bin_ready = 1'b1;
                if (bin_valid && ((suffix_cnt + 7'd1) == suffix_len)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (sym_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Configuration latch and prefix/suffix accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rice       <= '0;
            limited    <= 1'b0;
            range_m    <= '0;
            prefix_cnt <= '0;
            suffix_reg <= '0;
            suffix_cnt <= '0;
            suffix_len <= '0;
            cap_err    <= 1'b0;
`ifdef GR_BITCOUNT_EN
            total_bits <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rice       <= ui16AbsGoRice[3:0];
                        limited    <= useLimitedPrefixLength;
                        range_m    <= maxLog2TrDynamicRange;
                        prefix_cnt <= '0;
                        suffix_reg <= '0;
                        suffix_cnt <= '0;
                        suffix_len <= '0;
                        cap_err    <= 1'b0;
`ifdef GR_BITCOUNT_EN
                        total_bits <= '0;
`endif
                    end
                end
                PREFIX: begin
                    if (bin_valid) begin
                        prefix_cnt <= prefix_next;
`ifdef GR_BITCOUNT_EN
                        total_bits <= total_bits + 8'd1;
`endif
                        if (prefix_end) begin
                            suffix_len <= end_len;
                            cap_err    <= !limited && bin && (prefix_next == 7'(PREFIX_CAP));
                        end
                    end
                end
                SUFFIX: begin
                    if (bin_valid) begin
                        suffix_reg <= {suffix_reg[GR_ACC_W-2:0], bin};
                        suffix_cnt <= suffix_cnt + 7'd1;
`ifdef GR_BITCOUNT_EN
                        total_bits <= total_bits + 8'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    gr_symbol_build #(
        .SYM_W (SYM_W)
    ) u_symbol_build (
        .prefix   (prefix_cnt),
        .suffix   (suffix_reg),
        .rice     (rice),
        .sym      (built_sym),
        .overflow (built_ovf)
    );

    assign sym_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sym       = sym_valid ? built_sym : '0;
    assign err       = sym_valid && (built_ovf || cap_err);

endmodule

// File: tb/tb_golomb_rice_bin_decoder.sv
// tb/tb_golomb_rice_bin_decoder.sv - directed self-checking bench for golomb_rice_bin_decoder
module tb_golomb_rice_bin_decoder;

    localparam int SYM_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      rice_in;
    logic             lim_in;
    logic [4:0]       m_in;
    logic             bin_valid;
    logic             bin;
    logic             bin_ready;
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] sym;
    logic             err;
    logic             busy;
`ifdef GR_BITCOUNT_EN
    logic [7:0]       total_bits;
`endif

    int errors = 0;
    int checks = 0;

    // Free-running clock
    always #5 clk = ~clk;

    golomb_rice_bin_decoder #(
        .SYM_W      (SYM_W),
        .PREFIX_CAP (32)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .ui16AbsGoRice          (rice_in),
        .useLimitedPrefixLength (lim_in),
        .maxLog2TrDynamicRange  (m_in),
        .bin_valid              (bin_valid),
        .bin                    (bin),
        .bin_ready              (bin_ready),
        .sym_valid              (sym_valid),
        .sym_ready              (sym_ready),
        .sym                    (sym),
        .err                    (err),
        .busy                   (busy)
`ifdef GR_BITCOUNT_EN
        ,
        .total_bits             (total_bits)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [15:0] r, input logic lim, input logic [4:0] m);
        rice_in = r;
        lim_in  = lim;
        m_in    = m;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send(input logic [63:0] vec, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bin_valid = 1'b1;
            bin       = vec[i];
            @(negedge clk);
        end
        bin_valid = 1'b0;
        bin       = 1'b0;
    endtask

    task automatic finish_tx(input string tag, input logic [15:0] es, input logic ee, input int eb);
        check({tag, "_valid"}, sym_valid, 1'b1);
        check({tag, "_sym"}, sym, es);
        check({tag, "_err"}, err, ee);
        check({tag, "_rdy_done"}, bin_ready, 1'b0);
`ifdef GR_BITCOUNT_EN
        check({tag, "_bits"}, total_bits, eb[7:0]);
`endif
        sym_ready = 1'b1;
        @(negedge clk);
        sym_ready = 1'b0;
        check({tag, "_idle"}, {sym_valid, busy}, 2'b00);
    endtask

    task automatic run(input string tag, input logic [15:0] r, input logic lim, input logic [4:0] m,
                       input logic [63:0] vec, input int n, input logic [15:0] es, input logic ee,
                       input int eb);
        start_tx(r, lim, m);
        check({tag, "_busy"}, {busy, bin_ready, sym_valid}, 3'b110);
        send(vec, n);
        finish_tx(tag, es, ee, eb);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        rice_in   = '0;
        lim_in    = 1'b0;
        m_in      = '0;
        bin_valid = 1'b0;
        bin       = 1'b0;
        sym_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", {bin_ready, sym_valid, err, busy, sym}, 20'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", {bin_ready, sym_valid, err, busy, sym}, 20'h0);

        // Bins offered in IDLE are refused and do not start anything
        bin_valid = 1'b1;
        bin       = 1'b1;
        @(negedge clk);
        check("idle_no_accept", {bin_ready, busy}, 2'b00);
        bin_valid = 1'b0;
        bin       = 1'b0;

        // Directed vectors; upper rice bits must be ignored in T1
        run("t1", 16'hFFF1, 1'b0, 5'd0,  64'b1100, 4, 16'd4, 1'b0, 4);
        run("t2", 16'd2, 1'b0, 5'd0,  64'b11111111000010, 14, 16'd50, 1'b0, 14);
        run("t3", 16'd2, 1'b1, 5'd10, 64'b111111101000, 12, 16'd40, 1'b0, 12);
        run("t4", 16'd2, 1'b1, 5'd10, {37'h0, 17'h1FFFF, 10'b0000000011}, 27, 16'd16403, 1'b0, 27);
        run("t5", 16'd4, 1'b0, 5'd0,  {24'h0, 20'hFFFFF, 20'h00000}, 40, 16'hFFFF, 1'b1, 40);

        // Zero-length suffix and the unary/escape boundary at P = 4 / 5
        run("p0", 16'd0, 1'b0, 5'd0, 64'b0, 1, 16'd0, 1'b0, 1);
        run("p1", 16'd0, 1'b0, 5'd0, 64'b10, 2, 16'd1, 1'b0, 2);
        run("p4", 16'd0, 1'b0, 5'd0, 64'b11110, 5, 16'd4, 1'b0, 5);
        run("p5", 16'd0, 1'b0, 5'd0, 64'b111110, 6, 16'd5, 1'b0, 6);

        // Unlimited prefix reaching the cap: no terminator, 27 suffix bins, err raised
        run("cap", 16'd0, 1'b0, 5'd0, {5'h0, 32'hFFFFFFFF, 27'h0}, 59, 16'hFFFF, 1'b1, 59);

        // T6: bin gaps, ignored start pulses, held sym_ready
        start_tx(16'd1, 1'b0, 5'd0);
        send(64'b1, 1);
        start     = 1'b1;
        rice_in   = 16'd5;
        @(negedge clk);
        start     = 1'b0;
        check("t6_gap_rdy", {bin_ready, busy, sym_valid}, 3'b110);
        send(64'b1, 1);
        @(negedge clk);
        @(negedge clk);
        check("t6_gap2", {bin_ready, sym_valid}, 2'b10);
        send(64'b00, 2);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            @(negedge clk);
            start = 1'b0;
            check("t6_hold", {sym_valid, err, sym}, {2'b10, 16'd4});
        end
        finish_tx("t6", 16'd4, 1'b0, 4);

        // Reset in the middle of the suffix discards the partial symbol
        start_tx(16'd2, 1'b0, 5'd0);
        send(64'b111111110, 9);
        send(64'b00, 2);
        check("t6_in_suffix", {busy, bin_ready, sym_valid}, 3'b110);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_async", {bin_ready, sym_valid, err, busy, sym}, 20'h0);
        @(negedge clk);
        check("t6_rst_cycle", {bin_ready, sym_valid, err, busy, sym}, 20'h0);
        rst = 1'b0;
        @(negedge clk);
        run("t6_after", 16'd1, 1'b0, 5'd0, 64'b1100, 4, 16'd4, 1'b0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
